// File: rtl/rtc_pkg.sv
// ---------------------------------------------------------------------------
// rtc_pkg
// Definitions shared by the RTC transaction scheduler and its arbiter:
//   - Control codes understood by the bus engine datapath blocks
//   - bit positions inside the pending-request vector
//   - scheduler FSM state encoding
//   - helper that maps a Control code onto its one-hot acknowledge position
// ---------------------------------------------------------------------------
package rtc_pkg;

  // Control[1:0] codes as decoded by the datapath
  localparam logic [1:0] CTRL_LECTURA   = 2'd0;
  localparam logic [1:0] CTRL_ESCRITURA = 2'd1;
  localparam logic [1:0] CTRL_CRONO     = 2'd2;
  localparam logic [1:0] CTRL_STATUS    = 2'd3;

  // Bit positions in pend[3:0] = {status, escritura, crono, lectura}.
  // The bit order follows priority, not the Control code value.
  localparam int P_LECTURA   = 0;
  localparam int P_CRONO     = 1;
  localparam int P_ESCRITURA = 2;
  localparam int P_STATUS    = 3;

  typedef enum logic [2:0] {
    REPOSO   = 3'd0,
    ARRANQUE = 3'd1,
    ESPERA   = 3'd2,
    CIERRE   = 3'd3,
    PAUSA    = 3'd4
  } estado_t;

  // Control code -> one-hot in pend/ack bit order
  function automatic logic [3:0] ctrl_a_onehot(input logic [1:0] code);
    logic [3:0] oh;
    oh = '0;
    case (code)
      CTRL_STATUS:    oh[P_STATUS]    = 1'b1;
      CTRL_ESCRITURA: oh[P_ESCRITURA] = 1'b1;
      CTRL_CRONO:     oh[P_CRONO]     = 1'b1;
      default:        oh[P_LECTURA]   = 1'b1;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/secuenciador_rtc_arbitro_prioridad.sv
// ---------------------------------------------------------------------------
// arbitro_prioridad
// Purely combinational fixed-priority encoder for the RTC scheduler.
// Priority: status > escritura > crono > lectura. No fairness by design.
// Ports:
//   i_pend   [3:0] pending requests {status, escritura, crono, lectura}
//   o_grant  [3:0] one-hot grant in the same bit order (0 when nothing pending)
//   o_code   [1:0] Control code of the granted source
//   o_valido       at least one request pending
// ---------------------------------------------------------------------------
module arbitro_prioridad
  import rtc_pkg::*;
(
  input  logic [3:0] i_pend,
  output logic [3:0] o_grant,
  output logic [1:0] o_code,
  output logic       o_valido
);

  always_comb begin
    o_grant  = '0;
    o_code   = CTRL_LECTURA;
    o_valido = |i_pend;
    if (i_pend[P_STATUS]) begin
      o_grant[P_STATUS] = 1'b1;
      o_code            = CTRL_STATUS;
    end else if (i_pend[P_ESCRITURA]) begin
      o_grant[P_ESCRITURA] = 1'b1;
      o_code               = CTRL_ESCRITURA;
    end else if (i_pend[P_CRONO]) begin
      o_grant[P_CRONO] = 1'b1;
      o_code           = CTRL_CRONO;
    end else if (i_pend[P_LECTURA]) begin
      o_grant[P_LECTURA] = 1'b1;
      o_code             = CTRL_LECTURA;
    end
  end

endmodule

// File: rtl/secuenciador_rtc.sv
// ---------------------------------------------------------------------------
// secuenciador_rtc
// Transaction scheduler for the RTC bus engine. Latches four request
// sources into a pending register, grants them by fixed priority, issues a
// Control code plus a one-cycle start strobe, waits for the engine's
// completion pulse (or aborts on timeout) and acknowledges the requester.
// A configurable idle gap separates consecutive transactions.
//
// Parameters:
//   TIMEOUT  cycles allowed in ESPERA without fin_trans before abort (>=1)
//   GAP      idle cycles forced after each transaction (0 allowed)
// Ports:
//   reloj, resetM          clock / asynchronous active-high reset
//   req_status             request status modification   (Control=3)
//   req_escritura          request time/date write       (Control=1)
//   req_crono              request chrono write          (Control=2)
//   tick_lectura           periodic time read            (Control=0)
//   fin_trans              completion pulse from bus engine
//   Control[1:0]           code of the active transaction, 0 when idle
//   inicio                 one-cycle start pulse
//   ocupado                transaction in progress (ARRANQUE..CIERRE)
//   ack_*                  one-cycle completion pulse per source
//   error_timeout          one-cycle pulse on abort
// All outputs are decoded from registers only.
// ---------------------------------------------------------------------------
module secuenciador_rtc
  import rtc_pkg::*;
#(
  parameter int TIMEOUT = 2048,
  parameter int GAP     = 4
) (
  input  logic       reloj,
  input  logic       resetM,
  input  logic       req_status,
  input  logic       req_escritura,
  input  logic       req_crono,
  input  logic       tick_lectura,
  input  logic       fin_trans,
  output logic [1:0] Control,
  output logic       inicio,
  output logic       ocupado,
  output logic       ack_status,
  output logic       ack_escritura,
  output logic       ack_crono,
  output logic       ack_lectura,
  output logic       error_timeout
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_ULT = TMO_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_ULT = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

  estado_t          r_estado, w_estado_sig;
  logic [3:0]       r_pend;
  logic [1:0]       r_ctrl;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_err;

  logic [3:0]       w_req;
  logic [3:0]       w_grant;
  logic [3:0]       w_clr;
  logic [3:0]       w_ack;
  logic [1:0]       w_code;
  logic             w_valido;
  logic             w_tmo_fin;
  logic             w_gap_fin;

  assign w_req = {req_status, req_escritura, req_crono, tick_lectura};

  // Last ESPERA cycle; fin_trans arriving on it still counts as completion.
  assign w_tmo_fin = (r_tmo_cnt == TMO_ULT);
  // With GAP=0 PAUSA is only reachable after a timeout and lasts one cycle.
  assign w_gap_fin = (GAP == 0) || (r_gap_cnt == GAP_ULT);

  arbitro_prioridad u_arbitro (
    .i_pend   (r_pend),
    .o_grant  (w_grant),
    .o_code   (w_code),
    .o_valido (w_valido)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge reloj or posedge resetM) begin
    if (resetM) r_estado <= REPOSO;
    else        r_estado <= w_estado_sig;
  end

  // ---------------- FSM: next state + outputs ----------------
  always_comb begin
    w_estado_sig = r_estado;
    w_clr        = '0;
    inicio       = 1'b0;
    ocupado      = 1'b0;
    Control      = CTRL_LECTURA;
    w_ack        = '0;
    case (r_estado)
      REPOSO: begin
        if (w_valido) begin
          w_estado_sig = ARRANQUE;
          w_clr        = w_grant;
        end
      end
      ARRANQUE: begin
        inicio       = 1'b1;
        ocupado      = 1'b1;
        Control      = r_ctrl;
        w_estado_sig = ESPERA;
      end
      ESPERA: begin
        ocupado = 1'b1;
        Control = r_ctrl;
        if (fin_trans)      w_estado_sig = CIERRE;
        else if (w_tmo_fin) w_estado_sig = PAUSA;
      end
      CIERRE: begin
        ocupado      = 1'b1;
        Control      = r_ctrl;
        w_ack        = ctrl_a_onehot(r_ctrl);
        w_estado_sig = (GAP > 0) ? PAUSA : REPOSO;
      end
      PAUSA: begin
        if (w_gap_fin) w_estado_sig = REPOSO;
      end
      default: w_estado_sig = REPOSO;
    endcase
  end

  assign {ack_status, ack_escritura, ack_crono, ack_lectura} = w_ack;
  assign error_timeout = r_err;

  // ---------------- Pending requests and granted code ----------------
  // A new request on the grant edge re-arms the bit (set wins over clear).
  always_ff @(posedge reloj or posedge resetM) begin
    if (resetM) begin
      r_pend <= '0;
      r_ctrl <= CTRL_LECTURA;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_req;
      if (r_estado == REPOSO && w_valido) r_ctrl <= w_code;
    end
  end

  // ---------------- Timeout / gap counters ----------------
  // Both are zeroed outside their own state, so neither can wrap.
  always_ff @(posedge reloj or posedge resetM) begin
    if (resetM) begin
      r_tmo_cnt <= '0;
      r_gap_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      if (r_estado == ESPERA) r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      else                    r_tmo_cnt <= '0;
      if (r_estado == PAUSA)  r_gap_cnt <= r_gap_cnt + GAP_W'(1);
      else                    r_gap_cnt <= '0;
      r_err <= (r_estado == ESPERA) && w_tmo_fin && !fin_trans;
    end
  end

endmodule

// File: tb/tb_secuenciador_rtc.sv
module tb_secuenciador_rtc;

  localparam int TMO = 8;
  localparam int GAP = 4;

  logic       reloj = 1'b0;
  logic       resetM;
  logic       req_status, req_escritura, req_crono, tick_lectura, fin_trans;
  logic [1:0] Control;
  logic       inicio, ocupado, ack_status, ack_escritura, ack_crono, ack_lectura, error_timeout;
  logic [3:0] w_ack;

  // second instance with GAP=0, own stimulus
  logic       z_req_status, z_req_escritura, z_req_crono, z_tick_lectura, z_fin;
  logic [1:0] z_ctrl;
  logic       z_inicio, z_ocupado, z_ack_s, z_ack_e, z_ack_c, z_ack_l, z_err;
  logic [3:0] z_ack;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  secuenciador_rtc #(.TIMEOUT(TMO), .GAP(GAP)) dut (
    .reloj(reloj), .resetM(resetM), .req_status(req_status), .req_escritura(req_escritura),
    .req_crono(req_crono), .tick_lectura(tick_lectura), .fin_trans(fin_trans),
    .Control(Control), .inicio(inicio), .ocupado(ocupado), .ack_status(ack_status),
    .ack_escritura(ack_escritura), .ack_crono(ack_crono), .ack_lectura(ack_lectura),
    .error_timeout(error_timeout));

  secuenciador_rtc #(.TIMEOUT(TMO), .GAP(0)) dut0 (
    .reloj(reloj), .resetM(resetM), .req_status(z_req_status), .req_escritura(z_req_escritura),
    .req_crono(z_req_crono), .tick_lectura(z_tick_lectura), .fin_trans(z_fin),
    .Control(z_ctrl), .inicio(z_inicio), .ocupado(z_ocupado), .ack_status(z_ack_s),
    .ack_escritura(z_ack_e), .ack_crono(z_ack_c), .ack_lectura(z_ack_l),
    .error_timeout(z_err));

  assign w_ack = {ack_status, ack_escritura, ack_crono, ack_lectura};
  assign z_ack = {z_ack_s, z_ack_e, z_ack_c, z_ack_l};

  always #5 reloj = ~reloj;
  always @(posedge reloj) cyc <= cyc + 1;

  // Control code -> expected {status, escritura, crono, lectura} ack pattern
  function automatic logic [3:0] ack_de(input logic [1:0] c);
    case (c)
      2'd3:    return 4'b1000;
      2'd1:    return 4'b0100;
      2'd2:    return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  task automatic tick();
    @(posedge reloj);
    #1;
  endtask

  task automatic clr_in();
    req_status = 0; req_escritura = 0; req_crono = 0; tick_lectura = 0; fin_trans = 0;
    z_req_status = 0; z_req_escritura = 0; z_req_crono = 0; z_tick_lectura = 0; z_fin = 0;
  endtask

  task automatic wait_inicio(input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max; i++) begin
      if (inicio === 1'b1) begin ok = 1; break; end
      tick();
    end
  endtask

  // Called on the inicio cycle: raise fin_trans lat cycles later, return on CIERRE.
  task automatic serve(input int lat);
    repeat (lat) tick();
    fin_trans = 1;
    tick();
    fin_trans = 0;
  endtask

  task automatic test_reset();
    bit ok;
    int n;
    resetM = 1; clr_in();
    repeat (3) tick();
    n_chk++;
    if ({Control, inicio, ocupado, w_ack, error_timeout} !== 9'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected 0", {Control, inicio, ocupado, w_ack, error_timeout});
    end
    resetM = 0;
    req_status = 1; tick(); req_status = 0;
    wait_inicio(5, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL reset_start: no inicio within bound"); end
    tick();
    req_crono = 1; tick(); req_crono = 0; tick();
    n_chk++;
    if ({Control, ocupado} !== {2'd3, 1'b1}) begin
      n_fail++; $display("FAIL reset_pre_espera: got ctrl=%0d ocu=%b expected ctrl=3 ocu=1", Control, ocupado);
    end
    #2 resetM = 1;
    #1;
    n_chk++;
    if ({Control, ocupado, inicio, dut.r_pend} !== 8'd0) begin
      n_fail++; $display("FAIL reset_async: got ctrl=%0d ocu=%b ini=%b pend=%b expected all 0", Control, ocupado, inicio, dut.r_pend);
    end
    tick();
    resetM = 0;
    n = 0;
    repeat (10) begin tick(); if (inicio || ocupado) n++; end
    n_chk++;
    if (n != 0) begin n_fail++; $display("FAIL reset_idle: got %0d busy cycles expected 0", n); end
  endtask

  task automatic test_single_status();
    req_status = 1; tick(); req_status = 0;           // rel 1
    n_chk++;
    if (inicio !== 1'b0) begin n_fail++; $display("FAIL single_early: got inicio=%b expected 0", inicio); end
    tick();                                            // rel 2
    n_chk++;
    if ({inicio, ocupado, Control} !== {1'b1, 1'b1, 2'd3}) begin
      n_fail++; $display("FAIL single_start: got ini=%b ocu=%b ctrl=%0d expected 1 1 3", inicio, ocupado, Control);
    end
    serve(8);                                          // fin at rel 10 (timeout cycle), rel 11
    n_chk++;
    if ({w_ack, ocupado, error_timeout} !== {4'b1000, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL single_ack: got ack=%b ocu=%b err=%b expected 1000 1 0", w_ack, ocupado, error_timeout);
    end
    tick();                                            // rel 12, PAUSA
    n_chk++;
    if ({ocupado, Control, error_timeout, w_ack} !== 8'd0) begin
      n_fail++; $display("FAIL single_pausa: got ocu=%b ctrl=%0d err=%b ack=%b expected 0", ocupado, Control, error_timeout, w_ack);
    end
    req_status = 1; tick(); req_status = 0;            // rel 13
    repeat (3) tick();                                 // rel 16: grant cycle
    n_chk++;
    if (inicio !== 1'b0) begin n_fail++; $display("FAIL single_gap: got inicio=%b at grant cycle expected 0", inicio); end
    tick();                                            // rel 17
    n_chk++;
    if (inicio !== 1'b1) begin n_fail++; $display("FAIL single_regrant: got inicio=%b expected 1", inicio); end
    serve(1);
    repeat (GAP + 1) tick();
  endtask

  task automatic test_priority();
    logic [1:0] exp_c [3];
    bit ok;
    int prev;
    exp_c = '{2'd1, 2'd2, 2'd0};
    prev = 0;
    req_crono = 1; tick_lectura = 1; req_escritura = 1; tick();
    req_crono = 0; tick_lectura = 0; req_escritura = 0;
    for (int k = 0; k < 3; k++) begin
      wait_inicio(20, ok);
      n_chk++;
      if (!ok || Control !== exp_c[k]) begin
        n_fail++; $display("FAIL prio_order%0d: got ctrl=%0d ok=%b expected %0d", k, Control, ok, exp_c[k]);
      end
      if (k > 0) begin
        n_chk++;
        if (cyc - prev != 3 + GAP + 1) begin
          n_fail++; $display("FAIL prio_period%0d: got %0d expected %0d", k, cyc - prev, 3 + GAP + 1);
        end
      end
      prev = cyc;
      serve(1);
      n_chk++;
      if (w_ack !== ack_de(exp_c[k])) begin
        n_fail++; $display("FAIL prio_ack%0d: got %b expected %b", k, w_ack, ack_de(exp_c[k]));
      end
    end
    repeat (GAP + 2) tick();
  endtask

  task automatic test_merge();
    int fin_at, n_ini, n_esc_ini, n_ack_e, n_ack_s;
    fin_at = -1; n_ini = 0; n_esc_ini = 0; n_ack_e = 0; n_ack_s = 0;
    for (int r = 0; r < 60; r++) begin
      if (inicio) begin n_ini++; fin_at = r + 3; if (Control == 2'd1) n_esc_ini++; end
      n_ack_e += int'(ack_escritura);
      n_ack_s += int'(ack_status);
      req_status    = (r == 0);
      req_escritura = (r == 3 || r == 4 || r == 14);
      fin_trans     = (r == fin_at);
      tick();
    end
    clr_in();
    n_chk++;
    if ({n_ini, n_esc_ini, n_ack_e, n_ack_s} !== {32'd3, 32'd2, 32'd2, 32'd1}) begin
      n_fail++; $display("FAIL merge_counts: got ini=%0d esc=%0d ack_e=%0d ack_s=%0d expected 3 2 2 1", n_ini, n_esc_ini, n_ack_e, n_ack_s);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    tick_lectura = 1; tick(); tick_lectura = 0;
    wait_inicio(5, ok);                                // s
    repeat (TMO) tick();                               // s+8, last ESPERA cycle
    n_chk++;
    if ({ok, error_timeout, ocupado, dut.r_pend[0]} !== 4'b1010) begin
      n_fail++; $display("FAIL tmo_before: got ok=%b err=%b ocu=%b pend0=%b expected 1 0 1 0", ok, error_timeout, ocupado, dut.r_pend[0]);
    end
    tick();                                            // s+9
    n_chk++;
    if ({error_timeout, ocupado, w_ack} !== {1'b1, 1'b0, 4'b0000}) begin
      n_fail++; $display("FAIL tmo_pulse: got err=%b ocu=%b ack=%b expected 1 0 0000", error_timeout, ocupado, w_ack);
    end
    tick_lectura = 1; tick(); tick_lectura = 0;        // s+10
    n_chk++;
    if ({error_timeout, w_ack} !== 5'd0) begin
      n_fail++; $display("FAIL tmo_once: got err=%b ack=%b expected 0", error_timeout, w_ack);
    end
    repeat (3) tick();                                 // s+13 REPOSO
    n_chk++;
    if (inicio !== 1'b0) begin n_fail++; $display("FAIL tmo_pausa: got inicio=%b expected 0", inicio); end
    tick();                                            // s+14
    n_chk++;
    if (inicio !== 1'b1) begin n_fail++; $display("FAIL tmo_return: got inicio=%b expected 1", inicio); end
    serve(1);
    repeat (GAP + 1) tick();
  endtask

  task automatic test_edges();
    bit ok;
    req_crono = 1; tick(); req_crono = 0;
    wait_inicio(5, ok);
    fin_trans = 1; tick(); fin_trans = 0;              // fin in ARRANQUE
    n_chk++;
    if ({ok, ocupado, w_ack} !== {1'b1, 1'b1, 4'b0000}) begin
      n_fail++; $display("FAIL edge_arranque: got ok=%b ocu=%b ack=%b expected 1 1 0000", ok, ocupado, w_ack);
    end
    fin_trans = 1; tick(); fin_trans = 0;              // CIERRE
    n_chk++;
    if (w_ack !== 4'b0010) begin n_fail++; $display("FAIL edge_ack: got %b expected 0010", w_ack); end
    tick();
    fin_trans = 1; tick(); fin_trans = 0;              // fin in PAUSA
    n_chk++;
    if ({ocupado, inicio, w_ack} !== 6'd0) begin
      n_fail++; $display("FAIL edge_pausa: got ocu=%b ini=%b ack=%b expected 0", ocupado, inicio, w_ack);
    end
    repeat (GAP + 2) tick();
    fin_trans = 1; tick(); tick(); fin_trans = 0;      // fin in REPOSO
    n_chk++;
    if ({ocupado, inicio, w_ack} !== 6'd0) begin
      n_fail++; $display("FAIL edge_reposo: got ocu=%b ini=%b ack=%b expected 0", ocupado, inicio, w_ack);
    end
  endtask

  task automatic test_gap0();
    z_req_crono = 1; tick(); tick();                   // rel 2
    n_chk++;
    if ({z_inicio, z_ctrl} !== {1'b1, 2'd2}) begin
      n_fail++; $display("FAIL gap0_start: got ini=%b ctrl=%0d expected 1 2", z_inicio, z_ctrl);
    end
    tick(); z_fin = 1; tick(); z_fin = 0;              // rel 4 CIERRE
    n_chk++;
    if (z_ack !== 4'b0010) begin n_fail++; $display("FAIL gap0_ack: got %b expected 0010", z_ack); end
    tick();                                            // rel 5 REPOSO directly
    n_chk++;
    if ({z_ocupado, z_inicio} !== 2'b00) begin
      n_fail++; $display("FAIL gap0_reposo: got ocu=%b ini=%b expected 0 0", z_ocupado, z_inicio);
    end
    tick();                                            // rel 6
    z_req_crono = 0;
    n_chk++;
    if (z_inicio !== 1'b1) begin n_fail++; $display("FAIL gap0_period: got inicio=%b expected 1", z_inicio); end
    tick(); z_fin = 1; tick(); z_fin = 0;
    repeat (2) tick();                                 // rel 10: set-wins re-request
    n_chk++;
    if ({z_inicio, z_err} !== 2'b10) begin
      n_fail++; $display("FAIL gap0_setwins: got ini=%b err=%b expected 1 0", z_inicio, z_err);
    end
    tick(); z_fin = 1; tick(); z_fin = 0;
    repeat (3) tick();
  endtask

  // Random traffic checked against a timestamp model of each transaction.
  task automatic test_random();
    logic [3:0] m_pend, rq, e_ack;
    logic [1:0] code, e_ctrl;
    int s, lat, f, free_at, busy_end;
    bit have, done, e_ini, e_ocu, e_err, in_esp;
    resetM = 1; clr_in(); tick(); resetM = 0;
    m_pend = '0; have = 0; done = 0; free_at = 0; s = 0; lat = 0; f = 0; code = 0;
    for (int c = 0; c < 600; c++) begin
      busy_end = done ? f + 1 : s + TMO;
      e_ini  = have && c == s;
      e_ocu  = have && c >= s && c <= busy_end;
      e_ctrl = e_ocu ? code : 2'd0;
      e_ack  = (have && done && c == f + 1) ? ack_de(code) : 4'd0;
      e_err  = have && !done && c == s + TMO + 1;
      n_chk += 5;
      if (inicio !== e_ini)         begin n_fail++; $display("FAIL rnd_inicio c=%0d: got %b expected %b", c, inicio, e_ini); end
      if (ocupado !== e_ocu)        begin n_fail++; $display("FAIL rnd_ocupado c=%0d: got %b expected %b", c, ocupado, e_ocu); end
      if (Control !== e_ctrl)       begin n_fail++; $display("FAIL rnd_control c=%0d: got %0d expected %0d", c, Control, e_ctrl); end
      if (w_ack !== e_ack)          begin n_fail++; $display("FAIL rnd_ack c=%0d: got %b expected %b", c, w_ack, e_ack); end
      if (error_timeout !== e_err)  begin n_fail++; $display("FAIL rnd_timeout c=%0d: got %b expected %b", c, error_timeout, e_err); end
      rq = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 5) == 0)};
      in_esp = have && c >= s + 1 && c <= (done ? f : s + TMO);
      {req_status, req_escritura, req_crono, tick_lectura} = rq;
      fin_trans = (have && done && c == f) || (!in_esp && $urandom_range(0, 9) == 0);
      if (c >= free_at && m_pend != 0) begin
        if (m_pend[3])      begin code = 2'd3; m_pend[3] = 0; end
        else if (m_pend[2]) begin code = 2'd1; m_pend[2] = 0; end
        else if (m_pend[1]) begin code = 2'd2; m_pend[1] = 0; end
        else                begin code = 2'd0; m_pend[0] = 0; end
        have = 1; s = c + 1;
        lat = $urandom_range(1, TMO + 3);
        done = lat <= TMO;
        f = s + lat;
        free_at = done ? f + 2 + GAP : s + TMO + 1 + GAP;
      end
      m_pend = m_pend | rq;
      tick();
    end
    clr_in();
  endtask

  initial begin
    resetM = 1; clr_in();
    test_reset();
    test_single_status();
    test_priority();
    test_merge();
    test_timeout();
    test_edges();
    test_gap0();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/secuenciador_rtc.md
Name: secuenciador_rtc

Overview:
- Transaction scheduler for the RTC bus engine.
- Collects four request sources: status-register modification, time write, chrono write, and the periodic time read.
- Arbitrates them by fixed priority and drives the shared Control[1:0] code plus a start strobe.
- Waits for the bus engine's completion, then acknowledges the requester. Sits between the user-interface logic and the datapath blocks that decode Control (the status-modify path acts when Control==3).

Parameters:
TIMEOUT, 2048, max cycles in ESPERA without fin_trans before abort (>=1)
GAP, 4, idle cycles forced between consecutive transactions (0 allowed)

Ports:
reloj  in  1  system clock, all state on rising edge
resetM  in  1  asynchronous active-high reset
req_status  in  1  pulse/level: request status-register modification (Control=3)
req_escritura  in  1  request time/date write (Control=1)
req_crono  in  1  request chrono write (Control=2)
tick_lectura  in  1  periodic read strobe (Control=0)
fin_trans  in  1  one-cycle pulse from bus engine: transaction complete
Control  out  2  transaction code; valid only while ocupado=1, else 0
inicio  out  1  one-cycle start pulse to bus engine
ocupado  out  1  high from ARRANQUE through CIERRE
ack_status, ack_escritura, ack_crono, ack_lectura  out  1 each  one-cycle completion pulse for the serviced type
error_timeout  out  1  one-cycle pulse on TIMEOUT abort

Behaviour:
- Reset (async, any state): FSM=REPOSO, all pending bits=0, counters=0, all outputs 0.
- Pending register pend[3:0] = {status, escritura, crono, lectura}.
  - Each bit is set on any cycle its input is high; requests merge, so one service covers multiple requests.
  - A bit is cleared on the edge that leaves REPOSO with that type granted.
  - A set and a clear on the same edge: the set wins, and the request stays pending.
- Priority: status > escritura > crono > lectura. Fixed; no fairness. Lectura can starve while higher requests keep arriving; that is intended.
- REPOSO:
  - If pend!=0, latch the granted code into Control, clear that bit, and go to ARRANQUE.
  - A request input high in REPOSO is visible in pend next cycle. Earliest inicio is 2 cycles after the request edge.
- ARRANQUE (1 cycle):
  - inicio=1, ocupado=1. fin_trans is ignored.
  - Clear timeout counter; go to ESPERA.
- ESPERA:
  - ocupado=1, Control held. Counter increments each cycle.
  - fin_trans=1 goes to CIERRE.
  - Counter reaching TIMEOUT-1 with no fin_trans pulses error_timeout and goes to PAUSA. No ack; the request is dropped.
  - fin_trans on the same cycle as timeout: fin_trans wins (normal completion).
- CIERRE (1 cycle):
  - ocupado=1, and the ack_* matching the latched Control pulses.
  - Go to PAUSA if GAP>0, else REPOSO.
- PAUSA:
  - ocupado=0, Control=0.
  - Counts GAP cycles, then REPOSO. Requests keep accumulating in pend.
- Back-to-back transactions: minimum period is 3+GAP+ESPERA cycles.
- fin_trans outside ESPERA: ignored, no state change.
- Widths:
  - Timeout counter is $clog2(TIMEOUT+1) bits.
  - Gap counter is $clog2(GAP+1) bits, minimum 1.
  - Neither counter wraps, since each is cleared on state entry.
- Outputs are registered (state-decoded from registers); no combinational path from inputs to outputs.

Decomposition:
- Shared package rtc_pkg holds:
  - Control code constants: CTRL_LECTURA=2'd0, CTRL_ESCRITURA=2'd1, CTRL_CRONO=2'd2, CTRL_STATUS=2'd3.
  - FSM state encoding: REPOSO, ARRANQUE, ESPERA, CIERRE, PAUSA.
- One sub-module: arbitro_prioridad. Combinational fixed-priority encoder, pend[3:0] -> grant one-hot plus 2-bit code. Kept separate for unit testing.
- Everything else stays in secuenciador_rtc.

Test Plan:
- Reset/idle: resetM=1 mid-ESPERA with Control=3 -> Control=0, ocupado=0, inicio=0, pend cleared immediately (async). After release, no transaction without requests.
- Single status write (GAP=4): req_status pulse at cycle 10 -> inicio=1 at cycle 12 with Control=3; fin_trans at cycle 20 -> ack_status at cycle 21, ocupado=0 at 22, next grant possible at cycle 26.
- Priority: req_crono, tick_lectura, req_escritura all high at the same cycle -> grants in order Control=1, then 2, then 0. Each is separated by GAP and acked with the matching ack_*.
- Merge and re-request: req_escritura pulsed twice before grant -> one transaction, one ack. req_escritura during its own ESPERA -> a second transaction follows after PAUSA.
- Timeout (TIMEOUT=8): grant lectura, no fin_trans -> error_timeout pulse exactly 8 cycles after entering ESPERA, no ack_lectura, pend[0]=0, FSM returns via PAUSA.
- Edge cases: fin_trans during ARRANQUE and during PAUSA -> ignored. fin_trans on the timeout cycle -> ack, no error. GAP=0 -> REPOSO directly after CIERRE.
